// File: rtl/synth_pkg.sv
// synth_pkg: shared constants for the voice mixer -- waveform codes,
// mix-pass FSM states and the default sample divider.
package synth_pkg;

  // 24 MHz / 1500 = 16 kHz output sample rate
  localparam int SAMPLE_DIV_DEFAULT = 1500;

  localparam logic [1:0] WAVE_SQUARE  = 2'b00;
  localparam logic [1:0] WAVE_SAW     = 2'b01;
  localparam logic [1:0] WAVE_TRI     = 2'b10;
  localparam logic [1:0] WAVE_SILENCE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } mix_state_e;

endpackage

// File: rtl/voice_mixer_if.sv
// voice_mixer_if: voice-configuration write port plus the mixed-sample
// outputs. The master drives configuration; the slave is the mixer.
interface voice_mixer_if #(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 24
);
  logic                          note_wr;
  logic [$clog2(NUM_VOICES)-1:0] voice_sel;
  logic [PHASE_W-1:0]            phase_inc;
  logic                          gate;
  logic [1:0]                    wave_sel;
  logic [7:0]                    sample;
  logic                          sample_stb;
  logic                          busy;

  modport master (
    output note_wr, voice_sel, phase_inc, gate, wave_sel,
    input  sample, sample_stb, busy
  );

  modport slave (
    input  note_wr, voice_sel, phase_inc, gate, wave_sel,
    output sample, sample_stb, busy
  );
endinterface

// File: rtl/sample_tick.sv
// sample_tick: free-running 0..DIV-1 counter; tick_o is high during the
// cycle in which the count equals DIV-1.
module sample_tick #(
  parameter int DIV = 1500
) (
  input  logic clk,
  input  logic srst,
  output logic tick_o
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count_q, count_d;

  // next count: wrap to zero on the tick cycle
  always_comb begin
    tick_o  = (count_q == CW'(DIV - 1));
    count_d = tick_o ? '0 : count_q + CW'(1);
  end

  // counter register
  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/voice_mixer.sv
// voice_mixer: NUM_VOICES phase-accumulator oscillators mixed into one
// unsigned 8-bit sample every SAMPLE_DIV clocks. A mix pass scans one voice
// per cycle, then registers the scaled, biased, clamped sum.
// Build option: define VOICE_MIXER_TRIANGLE_EN to include the triangle
// waveform; without it wave code 10 is silent and no fold logic exists.
module voice_mixer
  import synth_pkg::*;
#(
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEFAULT,
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 24
) (
  input  logic                          CLK_24MHZ,
  input  logic                          RST,
  input  logic                          note_wr_i,
  input  logic [$clog2(NUM_VOICES)-1:0] voice_sel_i,
  input  logic [PHASE_W-1:0]            phase_inc_i,
  input  logic                          gate_i,
  input  logic [1:0]                    wave_sel_i,
  output logic [7:0]                    sample_o,
  output logic                          sample_stb_o,
  output logic                          busy_o
);
  localparam int SEL_W = $clog2(NUM_VOICES);
  localparam int SHIFT = SEL_W - 1;
  // sum spans -NUM_VOICES*64 .. NUM_VOICES*63, one spare bit on top
  localparam int ACC_W = SEL_W + 8;
  localparam logic [ACC_W:0] BIAS = (ACC_W + 1)'(128);
`ifdef VOICE_MIXER_TRIANGLE_EN
  // triangle needs the phase MSB plus the 7 bits below it
  localparam int TOP_W = 8;
`else
  localparam int TOP_W = 7;
`endif

  logic tick;

  sample_tick #(.DIV(SAMPLE_DIV)) u_sample_tick (
    .clk    (CLK_24MHZ),
    .srst   (RST),
    .tick_o (tick)
  );

  mix_state_e              state_q, state_d;
  logic [SEL_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]              sample_q, sample_d;
  logic                    stb_q, stb_d;

  logic [NUM_VOICES-1:0][TOP_W-1:0] top_all;
  logic [NUM_VOICES-1:0]            gate_all;
  logic [NUM_VOICES-1:0][1:0]       wave_all;

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    logic [PHASE_W-1:0] inc_q, inc_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               gate_q, gate_d;
    logic [1:0]         wave_q, wave_d;
    logic               wr_hit;
    logic               scan_hit;

    assign wr_hit   = note_wr_i && (voice_sel_i == SEL_W'(gi));
    assign scan_hit = (state_q == ST_ACC) && (idx_q == SEL_W'(gi));

    // Scan advances the phase using the config in force this pass; a write
    // lands at the same edge, so it only shapes the next pass. A gate change
    // restarts the phase at zero and wins over the scan advance.
    always_comb begin
      inc_d   = inc_q;
      gate_d  = gate_q;
      wave_d  = wave_q;
      phase_d = phase_q;
      if (scan_hit) begin
        phase_d = gate_q ? phase_q + inc_q : '0;
      end
      if (wr_hit) begin
        inc_d  = phase_inc_i;
        gate_d = gate_i;
        wave_d = wave_sel_i;
        if (gate_i != gate_q) begin
          phase_d = '0;
        end
      end
    end

    // per-voice configuration and phase registers
    always_ff @(posedge CLK_24MHZ) begin
      if (RST) begin
        inc_q   <= '0;
        gate_q  <= 1'b0;
        wave_q  <= WAVE_SILENCE;
        phase_q <= '0;
      end else begin
        inc_q   <= inc_d;
        gate_q  <= gate_d;
        wave_q  <= wave_d;
        phase_q <= phase_d;
      end
    end

    assign top_all[gi]  = phase_q[PHASE_W-1 -: TOP_W];
    assign gate_all[gi] = gate_q;
    assign wave_all[gi] = wave_q;
  end

  logic [TOP_W-1:0]        cur_top;
  logic                    cur_gate;
  logic [1:0]              cur_wave;
  logic [6:0]              contrib;
  logic signed [ACC_W-1:0] contrib_ext;

  assign cur_top  = top_all[idx_q];
  assign cur_gate = gate_all[idx_q];
  assign cur_wave = wave_all[idx_q];

`ifdef VOICE_MIXER_TRIANGLE_EN
  logic [6:0] tri_fold;
  assign tri_fold = cur_top[7] ? ~cur_top[6:0] : cur_top[6:0];
`endif

  // Contribution as 7-bit two's complement; "x - 64" on a 7-bit x is x
  // with its top bit flipped.
  always_comb begin
    contrib = 7'd0;
    if (cur_gate) begin
      case (cur_wave)
        WAVE_SQUARE: contrib = cur_top[TOP_W-1] ? 7'h40 : 7'h3F;
        WAVE_SAW:    contrib = cur_top[TOP_W-1 -: 7] ^ 7'h40;
`ifdef VOICE_MIXER_TRIANGLE_EN
        WAVE_TRI:    contrib = tri_fold ^ 7'h40;
`endif
        default:     contrib = 7'd0;
      endcase
    end
  end

  assign contrib_ext = {{(ACC_W - 7){contrib[6]}}, contrib};

  logic signed [ACC_W-1:0] acc_shr;
  logic [ACC_W:0]          biased;
  logic [7:0]              mix_val;

  assign acc_shr = acc_q >>> SHIFT;
  assign biased  = {acc_shr[ACC_W-1], acc_shr} + BIAS;

  // clamp the biased sum into the unsigned 8-bit output range
  always_comb begin
    if (biased[ACC_W]) begin
      mix_val = 8'd0;
    end else if (|biased[ACC_W-1:8]) begin
      mix_val = 8'hFF;
    end else begin
      mix_val = biased[7:0];
    end
  end

  // mix-pass FSM: wait for tick, accumulate each voice, publish the sample
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    sample_d = sample_q;
    stb_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_ACC;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      ST_ACC: begin
        acc_d = acc_q + contrib_ext;
        idx_d = idx_q + SEL_W'(1);
        if (idx_q == SEL_W'(NUM_VOICES - 1)) begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        sample_d = mix_val;
        stb_d    = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and output registers
  always_ff @(posedge CLK_24MHZ) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      sample_q <= 8'd128;
      stb_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      sample_q <= sample_d;
      stb_q    <= stb_d;
    end
  end

  assign sample_o     = sample_q;
  assign sample_stb_o = stb_q;
  assign busy_o       = (state_q == ST_ACC) || (state_q == ST_OUT);
endmodule

// File: doc/voice_mixer.md
VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 1500; CLK_24MHZ cycles per output sample (16 kHz).
REQ-002 SHALL have parameter NUM_VOICES, default 4; number of oscillator voices (power of two, 2..8).
REQ-003 SHALL have parameter PHASE_W, default 24; phase accumulator width.
REQ-004 SHALL have port CLK_24MHZ  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-006 SHALL have port note_wr_i  input  1  one-cycle write strobe for voice configuration.
REQ-007 SHALL have port voice_sel_i  input  $clog2(NUM_VOICES)  voice index targeted by the write.
REQ-008 SHALL have port phase_inc_i  input  PHASE_W  per-sample phase increment (pitch).
REQ-009 SHALL have port gate_i  input  1  voice on (1) or off (0).
REQ-010 SHALL have port wave_sel_i  input  2  waveform: 00 square, 01 saw, 10 triangle, 11 silence.
REQ-011 SHALL have port sample_o  output  8  unsigned mixed sample, held stable between strobes; feeds the sigma-delta PWM stage directly.
REQ-012 SHALL have port sample_stb_o  output  1  one-cycle pulse on each sample_o update.
REQ-013 SHALL have port busy_o  output  1  high while a mix pass is in progress.

Function
REQ-014 SHALL count 0..SAMPLE_DIV-1 and wrap; the cycle where count==SAMPLE_DIV-1 is the tick.
REQ-015 SHALL run FSM IDLE -> ACC -> OUT -> IDLE; IDLE->ACC on tick, accumulator cleared, voice index 0.
REQ-016 In ACC SHALL process one voice per cycle in ascending index, leaving for OUT after voice NUM_VOICES-1.
REQ-017 In OUT SHALL register sample_o and assert sample_stb_o for exactly one cycle; the update is visible NUM_VOICES+2 cycles after the tick cycle.
REQ-018 busy_o SHALL be high exactly in ACC and OUT.
REQ-019 Per voice, contribution SHALL be computed from the phase before increment; then phase += phase_inc mod 2^PHASE_W.
REQ-020 Contribution SHALL be a signed 7-bit value c: square = phase MSB ? -64 : +63; saw = top 7 phase bits minus 64; triangle = (MSB ? ~next 7 bits : next 7 bits) minus 64; silence = 0.
REQ-021 A voice with gate 0 SHALL contribute 0 and have its phase held at 0.
REQ-022 Accumulator SHALL be signed, NUM_VOICES*64 range with no overflow; sample_o = ((sum >>> ($clog2(NUM_VOICES)-1)) + 128), clamped to 0..255.
REQ-023 note_wr_i SHALL update the selected voice's inc/gate/wave on the next edge; a write to the voice being scanned in that same cycle SHALL take effect from the next mix pass.
REQ-024 A write changing gate 1->0 SHALL zero that voice's phase; a 0->1 write SHALL start from phase 0.
REQ-025 Writes SHALL be accepted in any FSM state; no write is ever dropped.

Reset
REQ-026 On RST: counter 0, FSM IDLE, all voices gate 0 / inc 0 / wave 11 / phase 0, sample_o 8'd128, sample_stb_o 0, busy_o 0.
REQ-027 RST asserted mid-ACC SHALL abort the pass with no strobe; the first tick after release is SAMPLE_DIV cycles later.

Configuration
REQ-028 Macro VOICE_MIXER_TRIANGLE_EN SHALL compile in the triangle waveform; when undefined, wave_sel_i 10 SHALL behave as silence (11) and the fold logic SHALL be absent.

Structure
REQ-029 SHALL use package synth_pkg for the waveform code constants, FSM state enum, and SAMPLE_DIV default.
REQ-030 SHALL instantiate sub-module sample_tick (divider producing the tick); waveform decode stays inline.

Verification
REQ-031 Reset, no writes -> sample_o=128 at each strobe; strobe period exactly 1500 cycles.
REQ-032 Voice 0 square, inc=2^22, gate 1 -> successive samples 159,159,96,96, repeating.
REQ-033 Voice 0 saw, inc=2^22 -> samples 96,112,128,144 repeating.
REQ-034 All 4 voices square, inc 0, gate 1 -> sample_o=254; all set wave 10 without VOICE_MIXER_TRIANGLE_EN -> 128.
REQ-035 Write to voice 2 in the cycle it is scanned -> current sample uses old config; next sample uses new.
REQ-036 RST pulsed during ACC -> no strobe that pass; sample_o=128; next strobe 1500+NUM_VOICES+2 cycles after RST release.
